// File: rtl/mem_resp.sv
// Single-outstanding memory responder: accepts one read/write request, inserts
// WAIT wait states, then completes with a one-cycle ack and registered read data.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | accepting req; also the ack cycle after a completion
// S_WAIT | counting wait states down to the completion edge
// S_RESP | the next edge completes: array access, ack and err set
module mem_resp #(
   parameter int DW    = 32,
   parameter int AW    = 8,
   parameter int DEPTH = 256,
   parameter int WAIT  = 2
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          ack,
   output logic          busy,
   output logic          err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW-1:0]   mem [DEPTH];
   logic            in_range;
   logic [IW-1:0]   idx;

   assign in_range = {1'b0, addr_q} < DEPTH_L;
   assign idx      = addr_q[IW-1:0];

   // The ack cycle doubles as an IDLE cycle, so a held req is re-accepted on
   // the edge that drops ack, giving one transaction every WAIT+2 cycles.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state   <= S_IDLE;
         ack     <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               ack  <= 1'b0;
               err  <= 1'b0;
               busy <= req;
               if (req) begin
                  we_q    <= we;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  cnt     <= 4'(WAIT);
                  state   <= (WAIT > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= S_RESP;
            end
            S_RESP: begin
               ack   <= 1'b1;
               err   <= !in_range;
               if (!we_q) rdata <= in_range ? mem[idx] : '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Array is never reset; a reset on the completion edge suppresses the write.
   always_ff @(posedge clk) begin
      if (rst_f && state == S_RESP && we_q && in_range) mem[idx] <= wdata_q;
   end

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: a WAIT=2/DEPTH=200 instance for most scenarios
// and a WAIT=0 instance for back-to-back single-cycle completion.
module tb_mem_resp;

   logic        clk = 1'b0;
   logic        rst_f;
   logic        req, we;
   logic [7:0]  addr;
   logic [31:0] wdata, rdata;
   logic        ack, busy, err;

   logic        req_z, we_z;
   logic [7:0]  addr_z;
   logic [31:0] wdata_z, rdata_z;
   logic        ack_z, busy_z, err_z;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_resp #(.DW(32), .AW(8), .DEPTH(200), .WAIT(2)) dut (
      .clk(clk), .rst_f(rst_f), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .err(err)
   );

   mem_resp #(.DW(32), .AW(8), .DEPTH(256), .WAIT(0)) dut_z (
      .clk(clk), .rst_f(rst_f), .req(req_z), .we(we_z), .addr(addr_z), .wdata(wdata_z),
      .rdata(rdata_z), .ack(ack_z), .busy(busy_z), .err(err_z)
   );

   // Stimulus only: runs one transaction on dut and reports what it saw.
   task automatic txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic e,
                      output logic bz_acc, output logic ack_end, output logic bz_end);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
      bz_acc = busy;
      req = 1'b0; we = ~w; addr = ~a; wdata = ~d;
      lat = -1; rd = '0; e = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            lat = i; rd = rdata; e = err;
            break;
         end
      end
      @(posedge clk); #1;
      ack_end = ack;
      bz_end  = busy;
   endtask

   task automatic test_reset;
      rst_f = 1'b0;
      req = 0; we = 0; addr = 0; wdata = 0;
      req_z = 0; we_z = 0; addr_z = 0; wdata_z = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset: ack=%b busy=%b err=%b rdata=%h, want 0 0 0 00000000", ack, busy, err, rdata);
      end
      checks++;
      if (ack_z !== 1'b0 || busy_z !== 1'b0 || rdata_z !== 32'h0) begin
         errors++;
         $display("FAIL reset_w0: ack=%b busy=%b rdata=%h, want 0 0 00000000", ack_z, busy_z, rdata_z);
      end
      @(negedge clk);
      rst_f = 1'b1;
   endtask

   task automatic test_write_read;
      int lat; logic [31:0] rd; logic e, ba, ae, be;
      txn(1'b1, 8'h10, 32'hDEADBEEF, lat, rd, e, ba, ae, be);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
      checks++;
      if (ba !== 1'b1 || ae !== 1'b0 || be !== 1'b0) begin
         errors++; $display("FAIL wr_handshake: busy@accept=%b ack_end=%b busy_end=%b want 1 0 0", ba, ae, be);
      end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata_unchanged: got %h want 00000000", rd); end
      txn(1'b0, 8'h10, 32'h0, lat, rd, e, ba, ae, be);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
         errors++; $display("FAIL rd_data: got %h err=%b want deadbeef err=0", rd, e);
      end
      // read data is held after ack drops
      checks++;
      if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %h want deadbeef", rdata); end
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] rd; logic e, ba, ae, be;
      int ack_cyc[3];
      logic [31:0] ack_dat[3];
      int n;
      txn(1'b1, 8'h01, 32'h1111_0001, lat, rd, e, ba, ae, be);
      txn(1'b1, 8'h02, 32'h2222_0002, lat, rd, e, ba, ae, be);
      txn(1'b1, 8'h03, 32'h3333_0003, lat, rd, e, ba, ae, be);
      n = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 8'h01;
      for (int k = 0; k <= 13; k++) begin
         @(posedge clk); #1;
         if (ack && n < 3) begin ack_cyc[n] = k; ack_dat[n] = rdata; n++; end
         if (k == 0) addr = 8'h02;
         if (k == 4) addr = 8'h03;
         if (k == 8) req = 1'b0;
      end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d acks want 3", n); end
      else begin
         checks++;
         if (ack_cyc[0] !== 3 || ack_cyc[1] !== 7 || ack_cyc[2] !== 11) begin
            errors++; $display("FAIL b2b_timing: got %0d %0d %0d want 3 7 11", ack_cyc[0], ack_cyc[1], ack_cyc[2]);
         end
         checks++;
         if (ack_dat[0] !== 32'h1111_0001 || ack_dat[1] !== 32'h2222_0002 || ack_dat[2] !== 32'h3333_0003) begin
            errors++; $display("FAIL b2b_data: got %h %h %h want 11110001 22220002 33330003", ack_dat[0], ack_dat[1], ack_dat[2]);
         end
      end
   endtask

   task automatic test_out_of_range;
      int lat; logic [31:0] rd; logic e, ba, ae, be;
      txn(1'b1, 8'd199, 32'h0000_0077, lat, rd, e, ba, ae, be);
      txn(1'b1, 8'd200, 32'h0000_0005, lat, rd, e, ba, ae, be);
      checks++;
      if (lat !== 3 || e !== 1'b1) begin errors++; $display("FAIL oor_write: lat=%0d err=%b want 3 1", lat, e); end
      txn(1'b0, 8'd200, 32'h0, lat, rd, e, ba, ae, be);
      checks++;
      if (lat !== 3 || e !== 1'b1 || rd !== 32'h0) begin
         errors++; $display("FAIL oor_read: lat=%0d err=%b rdata=%h want 3 1 00000000", lat, e, rd);
      end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL oor_err_clear: got %b want 0", err); end
      txn(1'b0, 8'd199, 32'h0, lat, rd, e, ba, ae, be);
      checks++;
      if (rd !== 32'h0000_0077 || e !== 1'b0) begin
         errors++; $display("FAIL oor_neighbour: rdata=%h err=%b want 00000077 0", rd, e);
      end
   endtask

   task automatic test_reset_abort;
      int lat; logic [31:0] rd; logic e, ba, ae, be;
      logic saw_ack;
      txn(1'b1, 8'h20, 32'hA5A5_A5A5, lat, rd, e, ba, ae, be);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 32'h0000_1234;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      rst_f = 1'b0;
      saw_ack = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (ack) saw_ack = 1'b1;
      end
      checks++;
      if (saw_ack !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_noack: ack_seen=%b busy=%b want 0 0", saw_ack, busy);
      end
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata_reset: got %h want 00000000", rdata); end
      @(negedge clk);
      rst_f = 1'b1;
      txn(1'b0, 8'h20, 32'h0, lat, rd, e, ba, ae, be);
      checks++;
      if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL abort_old_value: got %h want a5a5a5a5", rd); end
   endtask

   task automatic test_wait0;
      logic exp_ack[5];
      logic exp_busy[5];
      logic [31:0] rd_seen;
      exp_ack  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      rd_seen = '0;
      @(negedge clk);
      req_z = 1'b1; we_z = 1'b1; addr_z = 8'h00; wdata_z = 32'h0000_CAFE;
      for (int k = 0; k <= 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (ack_z !== exp_ack[k] || busy_z !== exp_busy[k]) begin
            errors++; $display("FAIL w0_edge%0d: ack=%b busy=%b want %b %b", k, ack_z, busy_z, exp_ack[k], exp_busy[k]);
         end
         if (k == 3) rd_seen = rdata_z;
         if (k == 0) begin we_z = 1'b0; wdata_z = 32'hFFFF_FFFF; end
         if (k == 2) req_z = 1'b0;
      end
      checks++;
      if (rd_seen !== 32'h0000_CAFE) begin errors++; $display("FAIL w0_rdata: got %h want 0000cafe", rd_seen); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_back_to_back;
      test_out_of_range;
      test_reset_abort;
      test_wait0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
